t07_tft_arbiter: RTL and testbench
==================================

// Module: t07_tft_arbiter
// PURPOSE
//  Shares the single SPI TFT word transmitter between NREQ requesters (e.g. init/command sequencer, pixel streamer).
//  Round-robin grant per word; optional per-requester lock keeps the grant for bursts.
//  Latches the winner's 16-bit word, pulses write-initiate and waits for the transmitter's ack.
//  Then enforces an inter-word gap for chip-select recovery and returns a done pulse to the requester.
// PARAMETERS
//  NREQ       2     number of requesters (>=2)
//  DW         16    word width sent to the SPI transmitter
//  GAP        4     idle cycles after each ack before the next word (>=1)
//  MAX_BURST  16    max consecutive locked words before forced release
//  TIMEOUT    1023  ack-wait limit in cycles (used only with T07_TFT_ARB_TIMEOUT_EN)
// PORTS
//  hwclk        in   1         system clock
//  reset        in   1         reset, asynchronous, active-high
//  req          in   NREQ      per-requester word-pending level
//  lock         in   NREQ      keep grant after current word if req still high
//  data         in   NREQ*DW   requester words, requester i at [i*DW +: DW]
//  grant        out  NREQ      one-hot owner of the transmitter, 0 when idle
//  done         out  NREQ      1-cycle pulse: owner's word acked by transmitter
//  spi_in       out  DW        word to transmitter, stable from SEND until ack
//  spi_wi       out  1         1-cycle write-initiate pulse
//  spi_ack      in   1         transmitter word-complete pulse
//  busy         out  1         state != IDLE
//  timeout_err  out  1         sticky ack-timeout flag (tied 0 without macro)
// BEHAVIOUR
//  - All outputs are registered.
//  - Reset (any time, incl. mid-word): state IDLE; grant/done/spi_in/spi_wi/busy/timeout_err = 0.
//  - After reset the round-robin pointer (last) = NREQ-1, so requester 0 wins the first arbitration.
//  - States: IDLE -> SEND -> WAIT -> GAP -> (SEND | IDLE).
//  - IDLE: if |req at edge N, winner = first req after last, circularly.
//    At N+1: grant = onehot(winner), spi_in = data[winner], spi_wi = 1, burst count = 1, state SEND.
//  - SEND: exactly one cycle; spi_wi returns to 0; go to WAIT.
//  - WAIT: spi_in held; spi_ack sampled only here (ack during SEND/GAP/IDLE is ignored).
//    On spi_ack: done[owner] = 1 for one cycle, gap counter = 0, go to GAP.
//  - GAP: count GAP cycles. On the last one:
//    - if lock[owner] && req[owner] && burst < MAX_BURST: reload spi_in = data[owner], spi_wi = 1, burst++, go to SEND.
//    - else: last = owner, grant = 0, go to IDLE (a new arbitration takes >=1 IDLE cycle).
//  - Requester dropping req after grant: current word still completes, done still pulses.
//  - data is sampled only at SEND entry, so requesters may change it afterwards.
//  - Simultaneous req from all: strict rotation 0,1,..,NREQ-1,0; no requester waits more than NREQ-1 words.
//    With lock, the worst case is (NREQ-1)*MAX_BURST words.
//  - Throughput per word = 1 (SEND) + ack wait + GAP cycles (+1 IDLE if the grant changes).
// CONFIGURATION
//  T07_TFT_ARB_TIMEOUT_EN defined:
//  - A WAIT counter runs; at TIMEOUT cycles without spi_ack: timeout_err <= 1 (sticky until reset).
//  - No done pulse; go to GAP and then release the grant unconditionally (lock ignored).
//  T07_TFT_ARB_TIMEOUT_EN undefined:
//  - WAIT waits indefinitely, no counter is synthesized, timeout_err is constant 0.
// STRUCTURE
//  - Package t07_tft_arb_pkg: state enum (IDLE, SEND, WAIT, GAP) and the default DW/GAP localparams.
//  - Sub-module t07_rr_picker: combinational round-robin (req, last) -> winner index + valid.
//  - Top module holds the FSM, gap/burst/timeout counters and output registers.
// TESTING
//  1. Reset mid-WAIT with req=2'b11 -> next cycle: grant=0, spi_wi=0, busy=0.
//     After release, req0 gets the first grant.
//  2. req=2'b01, data0=16'h2A00, ack 5 cycles after wi -> grant=01 at N+1, spi_wi 1-cycle, spi_in=2A00.
//     done[0] on the ack+1 edge; grant drops after GAP=4 cycles.
//  3. req=2'b11 held, no lock, data0=16'hAAAA, data1=16'h5555 -> spi_in sequence AAAA,5555,AAAA,5555.
//     grant alternates 01,10,01,10.
//  4. lock[1]=1, req=2'b11, MAX_BURST=16 -> 16 consecutive words with grant=10.
//     Then requester 0 gets one word, then requester 1 again.
//  5. spi_ack pulsed during SEND and during GAP -> ignored: no extra done, state sequence unchanged.
//  6. Macro on, TIMEOUT=8, spi_ack never sent -> timeout_err=1 after 8 WAIT cycles, done stays 0.
//     Grant released even with lock=1; a next word from another requester proceeds normally.

Source files
------------

// File: rtl/t07_tft_arbiter_pkg.sv
// Shared types and default sizes for the SPI TFT word arbiter.
// The ST_ prefix on state names keeps them distinct from the GAP parameter.
package t07_tft_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    localparam int DEFAULT_DW  = 16;
    localparam int DEFAULT_GAP = 4;

endpackage

// File: rtl/t07_tft_arbiter_if.sv
// Requester and transmitter signals of the TFT word arbiter, bundled as one interface.
// The slave modport is the arbiter's view; the master modport is the view of the surrounding logic.
interface t07_tft_arbiter_if
    import t07_tft_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int DW   = DEFAULT_DW
);

    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    lock;
    logic [NREQ*DW-1:0] data;
    logic [NREQ-1:0]    grant;
    logic [NREQ-1:0]    done;
    logic [DW-1:0]      spi_in;
    logic               spi_wi;
    logic               spi_ack;
    logic               busy;
    logic               timeout_err;

    modport slave (
        input  req, lock, data, spi_ack,
        output grant, done, spi_in, spi_wi, busy, timeout_err
    );

    modport master (
        output req, lock, data, spi_ack,
        input  grant, done, spi_in, spi_wi, busy, timeout_err
    );

endinterface

// File: rtl/t07_tft_arbiter_rr_picker.sv
// Combinational round-robin picker: returns the first requester after 'last', circularly.
// The search walks from the farthest candidate to the nearest so the nearest hit wins.
module t07_rr_picker #(
    parameter int NREQ = 2,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [IW-1:0]   winner,
    output logic            valid
);

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int i = NREQ; i >= 1; i--) begin
            if (req[(int'(last) + i) % NREQ]) begin
                winner = IW'((int'(last) + i) % NREQ);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/t07_tft_arbiter.sv
// Round-robin owner of the single SPI TFT word transmitter, with optional per-requester burst lock.
// Optional ack-wait timeout is compiled in with `define T07_TFT_ARB_TIMEOUT_EN.
//
//  state   | meaning
//  --------+---------------------------------------------------------------
//  IDLE    | no owner; arbitrate among pending requests
//  SEND    | one cycle: spi_wi high, word latched on spi_in
//  WAIT    | waiting for spi_ack from the transmitter
//  GAP     | chip-select recovery; decide burst continue or release
module t07_tft_arbiter
    import t07_tft_arb_pkg::*;
#(
    parameter int NREQ      = 2,
    parameter int DW        = DEFAULT_DW,
    parameter int GAP       = DEFAULT_GAP,
    parameter int MAX_BURST = 16,
    parameter int TIMEOUT   = 1023
) (
    input logic               hwclk,
    input logic               reset,
    t07_tft_arbiter_if.slave  bus
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    state_t          state, state_nxt;
    logic [IW-1:0]   owner, owner_nxt;
    logic [IW-1:0]   last, last_nxt;
    logic [BW-1:0]   burst, burst_nxt;
    logic [GW-1:0]   gap_cnt, gap_cnt_nxt;
    logic [NREQ-1:0] grant, grant_nxt;
    logic [NREQ-1:0] done, done_nxt;
    logic [DW-1:0]   spi_in, spi_in_nxt;
    logic            spi_wi, spi_wi_nxt;
    logic            busy;

    logic [IW-1:0]   pick_idx;
    logic            pick_vld;
    logic            ack_hit;
    logic            to_hit;
    logic            to_release;
    logic            gap_last;
    logic            burst_more;

    t07_rr_picker #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_picker (
        .req    (bus.req),
        .last   (last),
        .winner (pick_idx),
        .valid  (pick_vld)
    );

    assign ack_hit    = (state == ST_WAIT) && bus.spi_ack;
    assign gap_last   = (gap_cnt == '0);
    // A timed-out word never extends a burst, whatever lock says.
    assign burst_more = bus.lock[owner] && bus.req[owner] &&
                        (burst < BW'(MAX_BURST)) && !to_release;

`ifdef T07_TFT_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] to_cnt;
    logic          to_err;

    assign to_hit = (state == ST_WAIT) && !bus.spi_ack && (to_cnt == '0);

    always_ff @(posedge hwclk or posedge reset) begin
        if (reset) begin
            to_cnt     <= '0;
            to_err     <= 1'b0;
            to_release <= 1'b0;
        end else begin
            if (state == ST_SEND)
                to_cnt <= TW'(TIMEOUT - 1);
            else if ((state == ST_WAIT) && (to_cnt != '0))
                to_cnt <= to_cnt - TW'(1);

            if (to_hit) begin
                to_err     <= 1'b1;
                to_release <= 1'b1;
            end else if (state == ST_IDLE) begin
                to_release <= 1'b0;
            end
        end
    end

    assign bus.timeout_err = to_err;
`else
    logic [31:0] unused_timeout;

    assign unused_timeout  = TIMEOUT;
    assign to_hit          = 1'b0;
    assign to_release      = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    always_ff @(posedge hwclk or posedge reset) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (pick_vld) state_nxt = ST_SEND;
            ST_SEND: state_nxt = ST_WAIT;
            ST_WAIT: if (ack_hit || to_hit) state_nxt = ST_GAP;
            ST_GAP: begin
                if (gap_last)
                    state_nxt = burst_more ? ST_SEND : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        owner_nxt   = owner;
        last_nxt    = last;
        burst_nxt   = burst;
        gap_cnt_nxt = gap_cnt;
        grant_nxt   = grant;
        done_nxt    = '0;
        spi_in_nxt  = spi_in;
        spi_wi_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_vld) begin
                    owner_nxt           = pick_idx;
                    grant_nxt           = '0;
                    grant_nxt[pick_idx] = 1'b1;
                    spi_in_nxt          = bus.data[int'(pick_idx)*DW +: DW];
                    spi_wi_nxt          = 1'b1;
                    burst_nxt           = BW'(1);
                end
            end
            ST_WAIT: begin
                if (ack_hit) begin
                    done_nxt[owner] = 1'b1;
                    gap_cnt_nxt     = GW'(GAP - 1);
                end else if (to_hit) begin
                    gap_cnt_nxt = GW'(GAP - 1);
                end
            end
            ST_GAP: begin
                if (!gap_last) begin
                    gap_cnt_nxt = gap_cnt - GW'(1);
                end else if (burst_more) begin
                    spi_in_nxt = bus.data[int'(owner)*DW +: DW];
                    spi_wi_nxt = 1'b1;
                    burst_nxt  = burst + BW'(1);
                end else begin
                    last_nxt  = owner;
                    grant_nxt = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge hwclk or posedge reset) begin
        if (reset) begin
            owner   <= '0;
            last    <= IW'(NREQ - 1);
            burst   <= '0;
            gap_cnt <= '0;
            grant   <= '0;
            done    <= '0;
            spi_in  <= '0;
            spi_wi  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            owner   <= owner_nxt;
            last    <= last_nxt;
            burst   <= burst_nxt;
            gap_cnt <= gap_cnt_nxt;
            grant   <= grant_nxt;
            done    <= done_nxt;
            spi_in  <= spi_in_nxt;
            spi_wi  <= spi_wi_nxt;
            busy    <= (state_nxt != ST_IDLE);
        end
    end

    assign bus.grant  = grant;
    assign bus.done   = done;
    assign bus.spi_in = spi_in;
    assign bus.spi_wi = spi_wi;
    assign bus.busy   = busy;

endmodule

// File: tb/tb_t07_tft_arbiter.sv
// Self-checking bench for t07_tft_arbiter: acts as the SPI transmitter and predicts every word.
// The timeout scenario is compiled only when T07_TFT_ARB_TIMEOUT_EN is defined.
module tb_t07_tft_arbiter;

    localparam int NREQ = 2;
    localparam int DW   = 16;
    localparam int MAXB = 16;

    logic hwclk;
    logic reset;

    int checks = 0;
    int errors = 0;

    int          m_last;
    int          m_owner;
    int          m_burst;
    logic [15:0] m_data;
    logic        exp_terr;

    logic [1:0]  obs_grant[$];
    logic [15:0] obs_data[$];

    t07_tft_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

    t07_tft_arbiter #(
        .NREQ      (NREQ),
        .DW        (DW),
        .GAP       (4),
        .MAX_BURST (MAXB),
        .TIMEOUT   (8)
    ) dut (
        .hwclk (hwclk),
        .reset (reset),
        .bus   (bus)
    );

    initial hwclk = 1'b0;
    always #5 hwclk = ~hwclk;

    function automatic logic [1:0] onehot(input int o);
        logic [1:0] v;
        v    = '0;
        v[o] = 1'b1;
        return v;
    endfunction

    function automatic int rr_pick(input logic [1:0] r, input int last);
        for (int k = 1; k <= NREQ; k++)
            if (r[(last + k) % NREQ]) return (last + k) % NREQ;
        return -1;
    endfunction

    task automatic do_reset();
        reset       = 1'b1;
        bus.req     = '0;
        bus.lock    = '0;
        bus.data    = '0;
        bus.spi_ack = 1'b0;
        repeat (2) @(negedge hwclk);
        checks++;
        if (bus.grant !== 2'b00 || bus.done !== 2'b00 || bus.spi_in !== 16'h0 ||
            bus.spi_wi !== 1'b0 || bus.busy !== 1'b0 || bus.timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: grant=%b done=%b spi_in=%h wi=%b busy=%b terr=%b, required all 0",
                     bus.grant, bus.done, bus.spi_in, bus.spi_wi, bus.busy, bus.timeout_err);
        end
        reset    = 1'b0;
        m_last   = NREQ - 1;
        m_burst  = 1;
        exp_terr = 1'b0;
        @(negedge hwclk);
    endtask

    // One word from SEND to the end of its gap; new inputs are applied right after SEND.
    task automatic serve_word(input int own, input logic [15:0] dat, input int dly, input bit rel,
                              input logic [1:0] nreq, input logic [1:0] nlock,
                              input logic [15:0] nd0, input logic [15:0] nd1, input bit spur);
        int n;
        n = 0;
        while (bus.spi_wi !== 1'b1 && n < 40) begin
            @(negedge hwclk);
            n++;
        end
        checks++;
        if (bus.spi_wi !== 1'b1) begin
            errors++;
            $display("FAIL wi_wait: spi_wi=%b after 40 cycles, required 1", bus.spi_wi);
            return;
        end
        checks++;
        if (bus.grant !== onehot(own) || bus.spi_in !== dat || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL send_word: grant=%b spi_in=%h busy=%b, required grant=%b spi_in=%h busy=1",
                     bus.grant, bus.spi_in, bus.busy, onehot(own), dat);
        end
        obs_grant.push_back(bus.grant);
        obs_data.push_back(bus.spi_in);
        bus.req  = nreq;
        bus.lock = nlock;
        bus.data = {nd1, nd0};
        if (spur) bus.spi_ack = 1'b1;
        @(negedge hwclk);
        bus.spi_ack = 1'b0;
        checks++;
        if (bus.spi_wi !== 1'b0) begin
            errors++;
            $display("FAIL wi_pulse: spi_wi=%b in WAIT, required 0", bus.spi_wi);
        end
        for (int i = 0; i < dly; i++) begin
            checks++;
            if (bus.done !== 2'b00 || bus.spi_in !== dat || bus.grant !== onehot(own)) begin
                errors++;
                $display("FAIL wait_hold: done=%b spi_in=%h grant=%b, required done=00 spi_in=%h grant=%b",
                         bus.done, bus.spi_in, bus.grant, dat, onehot(own));
            end
            @(negedge hwclk);
        end
        bus.spi_ack = 1'b1;
        @(negedge hwclk);
        bus.spi_ack = 1'b0;
        checks++;
        if (bus.done !== onehot(own)) begin
            errors++;
            $display("FAIL done_pulse: done=%b, required %b", bus.done, onehot(own));
        end
        @(negedge hwclk);
        if (spur) bus.spi_ack = 1'b1;
        checks++;
        if (bus.done !== 2'b00 || bus.grant !== onehot(own)) begin
            errors++;
            $display("FAIL gap_hold: done=%b grant=%b, required done=00 grant=%b",
                     bus.done, bus.grant, onehot(own));
        end
        @(negedge hwclk);
        bus.spi_ack = 1'b0;
        checks++;
        if (bus.done !== 2'b00 || bus.spi_wi !== 1'b0) begin
            errors++;
            $display("FAIL gap_quiet: done=%b wi=%b, required done=00 wi=0", bus.done, bus.spi_wi);
        end
        @(negedge hwclk);
        @(negedge hwclk);
        checks++;
        if (rel) begin
            if (bus.grant !== 2'b00 || bus.busy !== 1'b0 || bus.spi_wi !== 1'b0) begin
                errors++;
                $display("FAIL release: grant=%b busy=%b wi=%b, required grant=00 busy=0 wi=0",
                         bus.grant, bus.busy, bus.spi_wi);
            end
        end else begin
            if (bus.spi_wi !== 1'b1 || bus.grant !== onehot(own)) begin
                errors++;
                $display("FAIL burst_next: wi=%b grant=%b, required wi=1 grant=%b",
                         bus.spi_wi, bus.grant, onehot(own));
            end
        end
        checks++;
        if (bus.timeout_err !== exp_terr) begin
            errors++;
            $display("FAIL terr_level: timeout_err=%b, required %b", bus.timeout_err, exp_terr);
        end
    endtask

    task automatic play(input int n, input bit rnd, input logic [1:0] freq, input logic [1:0] flock,
                        input logic [15:0] fd0, input logic [15:0] fd1, input bit spur);
        for (int w = 0; w < n; w++) begin
            logic [1:0]  nr;
            logic [1:0]  nl;
            logic [15:0] a;
            logic [15:0] b;
            int          dly;
            bit          cont;
            if (rnd) begin
                nr  = 2'($urandom_range(1, 3));
                nl  = 2'($urandom_range(0, 3));
                a   = 16'($urandom);
                b   = 16'($urandom);
                dly = $urandom_range(0, 5);
            end else begin
                nr  = freq;
                nl  = flock;
                a   = fd0;
                b   = fd1;
                dly = w % 3;
            end
            cont = nl[m_owner] && nr[m_owner] && (m_burst < MAXB);
            serve_word(m_owner, m_data, dly, !cont, nr, nl, a, b, spur);
            if (cont) begin
                m_burst++;
            end else begin
                m_last  = m_owner;
                m_owner = rr_pick(nr, m_last);
                m_burst = 1;
            end
            m_data = (m_owner == 0) ? a : b;
        end
    endtask

    task automatic start_words(input logic [1:0] r, input logic [1:0] l,
                               input logic [15:0] d0, input logic [15:0] d1);
        bus.req  = r;
        bus.lock = l;
        bus.data = {d1, d0};
        m_owner  = rr_pick(r, m_last);
        m_burst  = 1;
        m_data   = (m_owner == 0) ? d0 : d1;
        obs_grant.delete();
        obs_data.delete();
    endtask

    task automatic test_reset();
        int n;
        do_reset();
        start_words(2'b11, 2'b00, 16'h1234, 16'h5678);
        n = 0;
        while (bus.spi_wi !== 1'b1 && n < 20) begin
            @(negedge hwclk);
            n++;
        end
        @(negedge hwclk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (bus.grant !== 2'b00 || bus.spi_wi !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 2'b00) begin
            errors++;
            $display("FAIL reset_async: grant=%b wi=%b busy=%b done=%b, required all 0",
                     bus.grant, bus.spi_wi, bus.busy, bus.done);
        end
        @(negedge hwclk);
        checks++;
        if (bus.grant !== 2'b00 || bus.spi_wi !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_wait: grant=%b wi=%b busy=%b, required all 0",
                     bus.grant, bus.spi_wi, bus.busy);
        end
        reset  = 1'b0;
        m_last = NREQ - 1;
        start_words(2'b11, 2'b00, 16'h1234, 16'h5678);
        play(2, 1'b0, 2'b11, 2'b00, 16'h1234, 16'h5678, 1'b0);
        checks++;
        if (obs_grant.size() < 1 || obs_grant[0] !== 2'b01) begin
            errors++;
            $display("FAIL reset_first_grant: first grant=%b, required 01",
                     (obs_grant.size() > 0) ? obs_grant[0] : 2'bxx);
        end
    endtask

    task automatic test_single();
        do_reset();
        bus.data = {16'h0000, 16'h2A00};
        bus.req  = 2'b01;
        @(negedge hwclk);
        checks++;
        if (bus.spi_wi !== 1'b1 || bus.grant !== 2'b01 || bus.spi_in !== 16'h2A00) begin
            errors++;
            $display("FAIL single_latency: wi=%b grant=%b spi_in=%h, required wi=1 grant=01 spi_in=2a00",
                     bus.spi_wi, bus.grant, bus.spi_in);
        end
        serve_word(0, 16'h2A00, 4, 1'b1, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0);
        repeat (3) @(negedge hwclk);
        checks++;
        if (bus.busy !== 1'b0 || bus.spi_wi !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_req: busy=%b wi=%b, required 0 0", bus.busy, bus.spi_wi);
        end
    endtask

    task automatic test_alternate();
        logic [15:0] exp_seq [4];
        do_reset();
        exp_seq = '{16'hAAAA, 16'h5555, 16'hAAAA, 16'h5555};
        start_words(2'b11, 2'b00, 16'hAAAA, 16'h5555);
        play(4, 1'b0, 2'b11, 2'b00, 16'hAAAA, 16'h5555, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= obs_data.size() || obs_data[i] !== exp_seq[i] ||
                obs_grant[i] !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
                errors++;
                $display("FAIL alternate_%0d: spi_in=%h grant=%b, required spi_in=%h grant=%b", i,
                         (i < obs_data.size()) ? obs_data[i] : 16'hxxxx,
                         (i < obs_grant.size()) ? obs_grant[i] : 2'bxx,
                         exp_seq[i], (i % 2 == 0) ? 2'b01 : 2'b10);
            end
        end
    endtask

    task automatic test_lock_burst();
        int run;
        do_reset();
        start_words(2'b11, 2'b10, 16'h1111, 16'h2222);
        play(19, 1'b0, 2'b11, 2'b10, 16'h1111, 16'h2222, 1'b0);
        run = 0;
        while (run + 1 < obs_grant.size() && obs_grant[run + 1] === 2'b10) run++;
        checks++;
        if (run != MAXB || obs_grant.size() != 19 || obs_grant[17] !== 2'b01 || obs_grant[18] !== 2'b10) begin
            errors++;
            $display("FAIL lock_burst: run of grant 10 = %0d words, then %b,%b; required 16 words, then 01,10",
                     run, (obs_grant.size() > 17) ? obs_grant[17] : 2'bxx,
                     (obs_grant.size() > 18) ? obs_grant[18] : 2'bxx);
        end
    endtask

    task automatic test_spurious_ack();
        do_reset();
        start_words(2'b11, 2'b00, 16'hC0DE, 16'hF00D);
        play(4, 1'b0, 2'b11, 2'b00, 16'hC0DE, 16'hF00D, 1'b1);
    endtask

    task automatic test_random();
        do_reset();
        start_words(2'b11, 2'b01, 16'h0F0F, 16'hF0F0);
        play(40, 1'b1, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0);
    endtask

`ifdef T07_TFT_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        do_reset();
        start_words(2'b11, 2'b01, 16'hBEEF, 16'hCAFE);
        bus.req = 2'b01;
        n = 0;
        while (bus.spi_wi !== 1'b1 && n < 20) begin
            @(negedge hwclk);
            n++;
        end
        bus.req = 2'b11;
        checks++;
        if (bus.spi_wi !== 1'b1 || bus.grant !== 2'b01) begin
            errors++;
            $display("FAIL to_send: wi=%b grant=%b, required 1 01", bus.spi_wi, bus.grant);
        end
        for (int k = 1; k <= 8; k++) begin
            @(negedge hwclk);
            checks++;
            if (bus.timeout_err !== 1'b0 || bus.done !== 2'b00) begin
                errors++;
                $display("FAIL to_early: wait cycle %0d terr=%b done=%b, required 0 00",
                         k, bus.timeout_err, bus.done);
            end
        end
        @(negedge hwclk);
        checks++;
        if (bus.timeout_err !== 1'b1 || bus.done !== 2'b00) begin
            errors++;
            $display("FAIL to_flag: terr=%b done=%b, required 1 00", bus.timeout_err, bus.done);
        end
        repeat (3) @(negedge hwclk);
        @(negedge hwclk);
        checks++;
        if (bus.grant !== 2'b00 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL to_release: grant=%b busy=%b, required 00 0", bus.grant, bus.busy);
        end
        exp_terr = 1'b1;
        m_last   = 0;
        m_owner  = 1;
        m_burst  = 1;
        m_data   = 16'hCAFE;
        play(1, 1'b0, 2'b11, 2'b01, 16'hBEEF, 16'hCAFE, 1'b0);
    endtask
`endif

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        bus.req     = '0;
        bus.lock    = '0;
        bus.data    = '0;
        bus.spi_ack = 1'b0;
        test_reset();
        test_single();
        test_alternate();
        test_lock_burst();
        test_spurious_ack();
        test_random();
`ifdef T07_TFT_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
